// File: rtl/mux_logic_unit_if.sv
// Stream-side bundle of the mux logic unit: operand beat in, result beat out,
// plus the custom truth-table write port and the handshake counter.
interface mux_logic_unit_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             tt_we;
   logic [3:0]       tt_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   logic             red_and;
   logic             red_or;
   logic             red_xor;
   logic [CNT_W-1:0] op_count;

   modport master (
      output in_valid, a, b, op, tt_we, tt_data, out_ready,
      input  in_ready, out_valid, y, red_and, red_or, red_xor, op_count
   );

   modport slave (
      input  in_valid, a, b, op, tt_we, tt_data, out_ready,
      output in_ready, out_valid, y, red_and, red_or, red_xor, op_count
   );
endinterface

// File: rtl/mux_logic_unit.sv
// Two-stage pipelined bitwise logic unit. Each result bit is a 4:1 mux tree
// (three 2:1 muxes) whose data inputs are a 4-bit truth table, so every
// 2-input function, including a programmable one, is built from muxes only.
module mux_logic_unit #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input logic             clk,
   input logic             rst_n,
   mux_logic_unit_if.slave bus
);

   // Truth tables indexed by {a,b}: bit 3 is a=1,b=1, bit 0 is a=0,b=0.
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_NOTA = 4'b0011;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XNOR = 4'b1001;

   logic             rdy_q;
   logic             adv1;
   logic             adv2;
   logic             accept;
   logic [3:0]       tt_reg;
   logic [3:0]       tt_sel;

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [3:0]       s1_tt;

   logic [WIDTH-1:0] m_lo;
   logic [WIDTH-1:0] m_hi;
   logic [WIDTH-1:0] mux_y;

   logic             s2_valid;
   logic [WIDTH-1:0] y_q;
   logic             red_and_q;
   logic             red_or_q;
   logic             red_xor_q;
   logic [CNT_W-1:0] cnt_q;

   assign adv2   = !s2_valid || bus.out_ready;
   assign adv1   = !s1_valid || adv2;
   assign accept = bus.in_valid && bus.in_ready;

   // rdy_q keeps in_ready low during reset and for the release cycle.
   assign bus.in_ready  = rdy_q && adv1;
   assign bus.out_valid = s2_valid;
   assign bus.y         = y_q;
   assign bus.red_and   = red_and_q;
   assign bus.red_or    = red_or_q;
   assign bus.red_xor   = red_xor_q;
   assign bus.op_count  = cnt_q;

   // Resolve the op code to its truth table; CUSTOM uses the pre-edge tt_reg.
   always_comb begin
      tt_sel = tt_reg;
      unique case (bus.op)
         3'd0:    tt_sel = TT_AND;
         3'd1:    tt_sel = TT_OR;
         3'd2:    tt_sel = TT_NOTA;
         3'd3:    tt_sel = TT_XOR;
         3'd4:    tt_sel = TT_NAND;
         3'd5:    tt_sel = TT_NOR;
         3'd6:    tt_sel = TT_XNOR;
         default: tt_sel = tt_reg;
      endcase
   end

   // Per-bit mux tree: b selects at the first level, a at the second.
   always_comb begin
      m_lo  = '0;
      m_hi  = '0;
      mux_y = '0;
      for (int i = 0; i < WIDTH; i++) begin
         m_lo[i]  = s1_b[i] ? s1_tt[1] : s1_tt[0];
         m_hi[i]  = s1_b[i] ? s1_tt[3] : s1_tt[2];
         mux_y[i] = s1_a[i] ? m_hi[i] : m_lo[i];
      end
   end

   // Input-ready enable, set on the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdy_q <= 1'b0;
      else        rdy_q <= 1'b1;
   end

   // Custom truth-table register, written independently of the stream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          tt_reg <= 4'b0000;
      else if (bus.tt_we)  tt_reg <= bus.tt_data;
   end

   // Stage 1: capture operands and resolved truth table on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_tt    <= 4'b0000;
      end else if (adv1) begin
         s1_valid <= accept;
         if (accept) begin
            s1_a  <= bus.a;
            s1_b  <= bus.b;
            s1_tt <= tt_sel;
         end
      end
   end

   // Stage 2: register the mux-tree result and its reductions; hold on stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         y_q       <= '0;
         red_and_q <= 1'b0;
         red_or_q  <= 1'b0;
         red_xor_q <= 1'b0;
      end else if (adv2) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            y_q       <= mux_y;
            red_and_q <= &mux_y;
            red_or_q  <= |mux_y;
            red_xor_q <= ^mux_y;
         end
      end
   end

   // Saturating count of output handshakes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (s2_valid && bus.out_ready && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mux_logic_unit.sv
// Bench for mux_logic_unit: a queue-based reference model checked every cycle,
// directed beats with literal expectations, and a randomized stream phase.
module tb_mux_logic_unit;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   mux_logic_unit_if #(.WIDTH(8), .CNT_W(16)) bus ();
   mux_logic_unit_if #(.WIDTH(8), .CNT_W(4))  bus4 ();

   mux_logic_unit #(.WIDTH(8), .CNT_W(16)) dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
   mux_logic_unit #(.WIDTH(8), .CNT_W(4))  dut_s (.clk(clk), .rst_n(rst_n), .bus(bus4));

   assign bus4.in_valid  = bus.in_valid;
   assign bus4.a         = bus.a;
   assign bus4.b         = bus.b;
   assign bus4.op        = bus.op;
   assign bus4.tt_we     = bus.tt_we;
   assign bus4.tt_data   = bus.tt_data;
   assign bus4.out_ready = bus.out_ready;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference function: what each op means, as plain word-level logic.
   function automatic logic [7:0] ref_y(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op, input logic [3:0] tt);
      logic [7:0] r;
      r = '0;
      case (op)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: r = ~a;
         3'd3: r = a ^ b;
         3'd4: r = ~(a & b);
         3'd5: r = ~(a | b);
         3'd6: r = ~(a ^ b);
         default: for (int i = 0; i < 8; i++) r[i] = tt[{a[i], b[i]}];
      endcase
      return r;
   endfunction

   typedef struct {
      logic [7:0] y;
      int         stamp;
   } ent_t;

   ent_t       mq[$];
   int         n_edge = 0;
   bit         rdy_m  = 1'b0;
   int         hs_cnt = 0;
   logic [3:0] tt_m   = 4'b0000;
   logic [7:0] got_y[$];
   logic [2:0] got_red[$];
   int         got_cyc[$];
   int         acc_cyc[$];

   // Model: beats in flight form a FIFO of at most two; a beat becomes
   // visible two edges after acceptance. Checked mid-cycle on the falling edge.
   always @(negedge clk) begin
      bit         exp_ov;
      bit         exp_ir;
      logic [7:0] e;
      int         sat;
      if (!rst_n) begin
         mq.delete();
         hs_cnt = 0;
         tt_m   = 4'b0000;
         rdy_m  = 1'b0;
         got_y.delete();
         got_red.delete();
         got_cyc.delete();
         acc_cyc.delete();
         chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
         chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
         chk("rst_y",         32'(bus.y),         32'd0);
         chk("rst_reds",      32'({bus.red_and, bus.red_or, bus.red_xor}), 32'd0);
         chk("rst_op_count",  32'(bus.op_count),  32'd0);
         chk("rst_op_count4", 32'(bus4.op_count), 32'd0);
      end else begin
         exp_ov = (mq.size() > 0) && (n_edge >= mq[0].stamp + 1);
         exp_ir = rdy_m && ((mq.size() < 2) || bus.out_ready);
         chk("out_valid",  32'(bus.out_valid),  32'(exp_ov));
         chk("in_ready",   32'(bus.in_ready),   32'(exp_ir));
         chk("out_valid4", 32'(bus4.out_valid), 32'(exp_ov));
         chk("in_ready4",  32'(bus4.in_ready),  32'(exp_ir));
         if (exp_ov) begin
            e = mq[0].y;
            chk("y",     32'(bus.y),  32'(e));
            chk("y4",    32'(bus4.y), 32'(e));
            chk("reds",  32'({bus.red_and, bus.red_or, bus.red_xor}),    32'({&e, |e, ^e}));
            chk("reds4", 32'({bus4.red_and, bus4.red_or, bus4.red_xor}), 32'({&e, |e, ^e}));
         end
         sat = (hs_cnt > 15) ? 15 : hs_cnt;
         chk("op_count",  32'(bus.op_count),  32'(hs_cnt));
         chk("op_count4", 32'(bus4.op_count), 32'(sat));
         if (bus.out_valid && bus.out_ready) begin
            got_y.push_back(bus.y);
            got_red.push_back({bus.red_and, bus.red_or, bus.red_xor});
            got_cyc.push_back(n_edge);
         end
         if (bus.in_valid && bus.in_ready) acc_cyc.push_back(n_edge);
         // Predict the coming rising edge.
         if (exp_ov && bus.out_ready) begin
            void'(mq.pop_front());
            hs_cnt++;
         end
         if (bus.in_valid && exp_ir)
            mq.push_back('{ref_y(bus.a, bus.b, bus.op, tt_m), n_edge + 1});
         if (bus.tt_we) tt_m = bus.tt_data;
         n_edge++;
         rdy_m = 1'b1;
      end
   end

   function automatic logic [7:0] gy(input int i);
      if (i < got_y.size()) return got_y[i];
      return 8'hxx;
   endfunction

   task automatic cyc(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.tt_we    = 1'b0;
   endtask

   task automatic beat(input logic [7:0] a_i, input logic [7:0] b_i, input logic [2:0] op_i,
                       input bit we, input logic [3:0] td, input int tmo, output bit ok);
      bus.a        = a_i;
      bus.b        = b_i;
      bus.op       = op_i;
      bus.tt_we    = we;
      bus.tt_data  = td;
      bus.in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < tmo && !ok; i++) begin
         @(negedge clk);
         ok = bus.in_ready;
         @(posedge clk);
         #1;
      end
      bus.tt_we = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         ok;
      int         base;
      logic [7:0] exp6 [6];
      logic [7:0] exp_st [4];
      exp6   = '{8'hEE, 8'h35, 8'h66, 8'h77, 8'h11, 8'h99};
      exp_st = '{8'h88, 8'hEE, 8'h66, 8'h11};

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.op        = '0;
      bus.tt_we     = 1'b0;
      bus.tt_data   = '0;
      bus.out_ready = 1'b1;
      cyc(3);
      rst_n = 1'b1;
      chk("in_ready_release_cycle", 32'(bus.in_ready), 32'd0);
      cyc(1);
      chk("in_ready_after_release", 32'(bus.in_ready), 32'd1);

      // Single AND beat: value, reductions and 2-cycle latency.
      beat(8'hCA, 8'hAC, 3'd0, 1'b0, 4'h0, 20, ok);
      chk("and_accept", 32'(ok), 32'd1);
      idle();
      cyc(4);
      chk("and_y", 32'(gy(0)), 32'h88);
      chk("and_reds", (got_red.size() > 0) ? 32'(got_red[0]) : 32'hDEAD, 32'b010);
      chk("and_latency", (got_cyc.size() > 0 && acc_cyc.size() > 0) ?
                         32'(got_cyc[0] - acc_cyc[0]) : 32'hDEAD, 32'd2);

      // Reset, then six back-to-back ops.
      rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
      for (int k = 1; k <= 6; k++) begin
         beat(8'hCA, 8'hAC, 3'(k), 1'b0, 4'h0, 20, ok);
         chk("b2b_accept", 32'(ok), 32'd1);
      end
      idle();
      cyc(4);
      for (int k = 0; k < 6; k++) chk("b2b_y", 32'(gy(k)), 32'(exp6[k]));
      chk("b2b_op_count", 32'(bus.op_count), 32'd6);
      chk("b2b_throughput", (got_cyc.size() == 6) ? 32'(got_cyc[5] - got_cyc[0]) : 32'hDEAD, 32'd5);

      // Custom truth table, including a write coincident with an accept.
      base = got_y.size();
      bus.tt_data = 4'b0100;
      bus.tt_we   = 1'b1;
      cyc(1);
      bus.tt_we = 1'b0;
      beat(8'hCA, 8'hAC, 3'd7, 1'b0, 4'b0000, 20, ok);
      beat(8'hCA, 8'hAC, 3'd7, 1'b1, 4'b1111, 20, ok);
      beat(8'hCA, 8'hAC, 3'd7, 1'b0, 4'b0000, 20, ok);
      idle();
      cyc(4);
      chk("custom_y",      32'(gy(base)),     32'h42);
      chk("custom_same_y", 32'(gy(base + 1)), 32'h42);
      chk("custom_next_y", 32'(gy(base + 2)), 32'hFF);

      // Stall: only two beats fit, output held, then everything drains in order.
      base = got_y.size();
      bus.out_ready = 1'b0;
      beat(8'hCA, 8'hAC, 3'd0, 1'b0, 4'h0, 20, ok);
      chk("stall_acc1", 32'(ok), 32'd1);
      beat(8'hCA, 8'hAC, 3'd1, 1'b0, 4'h0, 20, ok);
      chk("stall_acc2", 32'(ok), 32'd1);
      beat(8'hCA, 8'hAC, 3'd3, 1'b0, 4'h0, 5, ok);
      chk("stall_acc3_blocked", 32'(ok), 32'd0);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_y_held", 32'(bus.y), 32'h88);
      bus.out_ready = 1'b1;
      beat(8'hCA, 8'hAC, 3'd3, 1'b0, 4'h0, 20, ok);
      chk("stall_acc3", 32'(ok), 32'd1);
      beat(8'hCA, 8'hAC, 3'd5, 1'b0, 4'h0, 20, ok);
      chk("stall_acc4", 32'(ok), 32'd1);
      idle();
      cyc(5);
      for (int k = 0; k < 4; k++) chk("stall_order", 32'(gy(base + k)), 32'(exp_st[k]));
      chk("stall_count", 32'(got_y.size()), 32'(base + 4));

      // Asynchronous reset with two beats in flight.
      bus.out_ready = 1'b0;
      beat(8'h5A, 8'h3C, 3'd3, 1'b0, 4'h0, 20, ok);
      beat(8'hF0, 8'h0F, 3'd1, 1'b0, 4'h0, 20, ok);
      idle();
      chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
      rst_n = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      chk("async_out_valid", 32'(bus.out_valid), 32'd0);
      chk("async_y",         32'(bus.y),         32'd0);
      chk("async_op_count",  32'(bus.op_count),  32'd0);
      cyc(2);
      rst_n = 1'b1;
      cyc(5);
      chk("no_stale_beat", 32'(got_y.size()), 32'd0);
      chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

      // Randomized stream with random backpressure and table writes.
      for (int k = 0; k < 300; k++) begin
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.a         = 8'($urandom);
         bus.b         = 8'($urandom);
         bus.op        = 3'($urandom_range(0, 7));
         bus.tt_we     = ($urandom_range(0, 7) == 0);
         bus.tt_data   = 4'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         cyc(1);
      end
      idle();
      bus.out_ready = 1'b1;
      cyc(5);

      // Twenty more handshakes: the 4-bit counter must be pinned at 15.
      for (int k = 0; k < 20; k++) begin
         beat(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'b0, 4'h0, 20, ok);
         chk("sat_accept", 32'(ok), 32'd1);
      end
      idle();
      cyc(5);
      chk("sat_op_count4", 32'(bus4.op_count), 32'd15);
      chk("main_op_count_ge20", 32'(bus.op_count >= 16'd20), 32'd1);
      cyc(3);
      chk("sat_op_count4_stays", 32'(bus4.op_count), 32'd15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_logic_unit.md
Name: mux_logic_unit

Overview:
- Parametrised, pipelined successor to the mux-built gate block.
- Every result bit is a 4:1 mux tree built from three 2:1 mux stages. The mux data inputs are a 4-bit truth table, so any 2-input function (AND/OR/NOT/XOR/NAND/NOR/XNOR/custom) is realised by muxes alone.
- WIDTH-bit operands travel a 2-stage valid/ready pipeline. Stage 2 adds reduction flags and a handshake counter.
- Sits as a small ALU-style datapath element between a stream source and sink.

Parameters:
- WIDTH, 8, operand/result width in bits (>=1).
- CNT_W, 16, width of the saturating output-handshake counter (>=1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  function select: 0 AND, 1 OR, 2 NOT(a), 3 XOR, 4 NAND, 5 NOR, 6 XNOR, 7 CUSTOM.
- tt_we  input  1  write enable for the custom truth-table register.
- tt_data  input  4  custom truth table value.
- out_valid  output  1  result beat valid.
- out_ready  input  1  sink accepts the result.
- y  output  WIDTH  result.
- red_and  output  1  AND-reduction of y.
- red_or  output  1  OR-reduction of y.
- red_xor  output  1  XOR-reduction (parity) of y.
- op_count  output  CNT_W  number of completed output handshakes, saturating.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, y=0, red_and=0, red_or=0, red_xor=0, op_count=0, tt_reg=4'b0000, both stage valids=0. in_ready is forced 0 while rst_n is low and rises in the first cycle after release.
- Truth-table index: y[i] = tt[{a[i],b[i]}], where index 3 is a=1,b=1 and index 0 is a=0,b=0.
  - b[i] selects at the first mux level; a[i] selects at the second.
- Truth table per op:
  - AND 4'b1000, OR 4'b1110, NOT(a) 4'b0011, XOR 4'b0110.
  - NAND 4'b0111, NOR 4'b0001, XNOR 4'b1001, CUSTOM = tt_reg.
- tt_reg: loaded with tt_data on a clk edge where tt_we=1; tt_we is independent of the handshake.
- Stage 1 captures a, b and the resolved 4-bit truth table on input accept (in_valid && in_ready).
  - For CUSTOM, the truth table is resolved from the tt_reg value before the edge.
  - A tt_we in the same cycle as an accept therefore affects only later beats.
  - Already-captured beats never change.
- Stage 2 registers y (mux tree over the stage-1 contents) and the three reductions computed from that y.
- Flow control:
  - adv2 = !s2_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1
  - A combinational out_ready -> in_ready path is permitted.
- Latency is exactly 2 cycles from accept edge to out_valid with no stall. Throughput is 1 beat/cycle under continuous out_ready.
- Stall: while out_valid=1 and out_ready=0, y and the reductions are held stable. The pipeline holds at most 2 beats, then in_ready=0.
- Ordering is strictly in order, with no loss and no duplication across arbitrary valid/ready patterns.
- op_count increments by 1 on each output handshake (out_valid && out_ready) and saturates at 2^CNT_W-1 (no wrap).
- Reset asserted mid-stream discards all in-flight beats immediately. tt_reg returns to 0.
- Invalid/undefined op values do not exist; all 8 codes are defined.

Test Plan:
- WIDTH=8, a=0xCA, b=0xAC, op=AND, out_ready=1 -> y=0x88 exactly 2 cycles after accept; red_and=0, red_or=1, red_xor=0.
- Same operands, back-to-back ops OR, NOT, XOR, NAND, NOR, XNOR -> y = 0xEE, 0x35, 0x66, 0x77, 0x11, 0x99 on consecutive cycles; op_count=6.
- tt_we=1, tt_data=4'b0100, then CUSTOM with a=0xCA, b=0xAC -> y=0x42.
  - tt_we with tt_data=4'b1111 in the same cycle as a CUSTOM accept -> that beat still uses 4'b0100 (y=0x42); the next beat gives y=0xFF.
- Hold out_ready=0 while presenting 4 beats -> exactly 2 accepted, then in_ready=0 and y held stable. Raise out_ready -> all 4 results emerge in order, no duplicates.
- CNT_W=4, 20 output handshakes -> op_count=15 and remains 15.
- Pull rst_n low with 2 beats in flight -> out_valid=0, y=0, op_count=0 immediately (asynchronously). After release, in_ready=1 and no stale beat appears.
